pc_gen: RTL and testbench

Parametrised program-counter generator for the RISC-V fetch stage, the successor to the single-register PC. It holds the fetch address and presents it to instruction memory over a valid/ready request handshake. It advances sequentially, accepts branch/jump redirects and trap entry, and predicts return targets from a small return-address stack (RAS). It sits between the control/execute stages (redirect sources) and instruction memory.

---
 rtl/pc_gen.sv | 107 ++++++++++
 tb/tb_pc_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-stage program counter: sequential advance, redirect/trap selection and a
// circular return-address stack, presented to instruction memory over valid/ready.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              RAS_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        req_valid,
  input  logic                        req_ready,
  output logic [XLEN-1:0]             req_addr,
  input  logic                        redirect_valid,
  input  logic [XLEN-1:0]             redirect_target,
  input  logic                        trap_valid,
  input  logic [XLEN-1:0]             trap_pc,
  input  logic                        call_push,
  input  logic [XLEN-1:0]             push_addr,
  input  logic                        ret_pop,
  output logic [XLEN-1:0]             epc,
  output logic                        misalign_exc,
  output logic                        ret_miss,
  output logic [$clog2(RAS_DEPTH):0]  ras_count,
  output logic                        fsm_state
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  // Handshake: a request transfers on a cycle where req_valid and req_ready are both
  // high; req_addr then advances. Redirects, traps and pops may replace an unaccepted
  // request (fetch flush).
  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_e;

  state_e              state_q;
  logic [XLEN-1:0]     pc;
  logic [XLEN-1:0]     next_pc;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       top_idx;
  logic [CW-1:0]       count;
  logic [XLEN-1:0]     ras [RAS_DEPTH];
  logic [XLEN-1:0]     ras_top;
  logic                misaligned;
  logic                ras_has;
  logic                pop_hit;

  assign req_addr  = pc;
  assign ras_count = count;
  assign fsm_state = state_q;

  always_comb begin
    misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);
    ras_has    = (count != '0);
    pop_hit    = ret_pop && ras_has;
    top_idx    = ptr - 1'b1;
    ras_top    = ras[top_idx];
    next_pc    = pc;
    if (trap_valid)                next_pc = TRAP_VECTOR;
    else if (misaligned)           next_pc = TRAP_VECTOR;
    else if (redirect_valid)       next_pc = redirect_target;
    else if (pop_hit)              next_pc = ras_top;
    else if (req_valid && req_ready) next_pc = pc + XLEN'(4);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT;
      pc           <= RESET_VECTOR;
      epc          <= '0;
      count        <= '0;
      ptr          <= '0;
      misalign_exc <= 1'b0;
      ret_miss     <= 1'b0;
      req_valid    <= 1'b0;
    end else if (state_q == BOOT) begin
      state_q   <= RUN;
      req_valid <= 1'b1;
    end else begin
      pc           <= next_pc;
      misalign_exc <= !trap_valid && misaligned;
      ret_miss     <= ret_pop && !ras_has;
      if (trap_valid)      epc <= trap_pc;
      else if (misaligned) epc <= redirect_target;
      // A combined push/pop rewrites the top in place, so pointer and count stay put.
      if (call_push && pop_hit) begin
        ptr   <= ptr;
        count <= count;
      end else if (pop_hit) begin
        ptr   <= ptr - 1'b1;
        count <= count - 1'b1;
      end else if (call_push) begin
        ptr   <= ptr + 1'b1;
        count <= (count == CW'(RAS_DEPTH)) ? count : count + 1'b1;
      end
    end
  end

  // Entry storage needs no reset: count guards every read.
  always_ff @(posedge clk) begin
    if (state_q == RUN && call_push) begin
      if (pop_hit) ras[top_idx] <= push_addr;
      else         ras[ptr]     <= push_addr;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: queue-based reference model checked every cycle, plus
// hand-computed expectations from the boot, backpressure, priority and RAS scenarios.
module tb_pc_gen;

  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RV = 32'h0;
  localparam logic [31:0] TV = 32'h100;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        call_push;
  logic [31:0] push_addr;
  logic        ret_pop;
  logic [31:0] epc;
  logic        misalign_exc;
  logic        ret_miss;
  logic [2:0]  ras_count;
  logic        fsm_state;

  int checks = 0;
  int errors = 0;

  pc_gen #(.XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_pc(trap_pc), .call_push(call_push),
    .push_addr(push_addr), .ret_pop(ret_pop), .epc(epc), .misalign_exc(misalign_exc),
    .ret_miss(ret_miss), .ras_count(ras_count), .fsm_state(fsm_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: PC rules evaluated directly, RAS held as a queue (back = top)
  logic [31:0] exp_q[$];
  logic        m_run = 1'b0;
  logic [31:0] m_pc = RV;
  logic [31:0] m_epc = '0;
  logic        m_mis = 1'b0;
  logic        m_miss = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 1'b0; m_pc = RV; m_epc = '0; m_mis = 1'b0; m_miss = 1'b0;
      exp_q.delete();
    end else if (!m_run) begin
      m_run = 1'b1;
    end else begin
      logic [31:0] nxt;
      logic        has;
      has = exp_q.size() > 0;
      nxt = m_pc;
      m_mis = 1'b0;
      m_miss = ret_pop && !has;
      if (trap_valid) begin
        nxt = TV; m_epc = trap_pc;
      end else if (redirect_valid && redirect_target % 4 != 0) begin
        nxt = TV; m_epc = redirect_target; m_mis = 1'b1;
      end else if (redirect_valid) begin
        nxt = redirect_target;
      end else if (ret_pop && has) begin
        nxt = exp_q[exp_q.size() - 1];
      end else if (req_ready) begin
        nxt = m_pc + 32'd4;
      end
      if (call_push && ret_pop && has) begin
        exp_q[exp_q.size() - 1] = push_addr;
      end else begin
        if (ret_pop && has) void'(exp_q.pop_back());
        if (call_push) begin
          exp_q.push_back(push_addr);
          if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
        end
      end
      m_pc = nxt;
    end
  end

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clk) begin
    chk("m_req_valid", {31'b0, req_valid}, {31'b0, m_run});
    chk("m_state", {31'b0, fsm_state}, {31'b0, m_run});
    chk("m_req_addr", req_addr, m_pc);
    chk("m_epc", epc, m_epc);
    chk("m_misalign", {31'b0, misalign_exc}, {31'b0, m_mis});
    chk("m_ret_miss", {31'b0, ret_miss}, {31'b0, m_miss});
    chk("m_ras_count", {29'b0, ras_count}, exp_q.size());
  end

  // driver tasks
  task automatic idle();
    redirect_valid = 0; redirect_target = '0; trap_valid = 0; trap_pc = '0;
    call_push = 0; push_addr = '0; ret_pop = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] a);
    call_push = 1; push_addr = a;
    tick();
    idle();
  endtask

  task automatic pop();
    ret_pop = 1;
    tick();
    idle();
  endtask

  logic [31:0] pops [4] = '{32'h50, 32'h40, 32'h30, 32'h20};

  initial begin
    reset = 1; req_ready = 0;
    idle();
    repeat (2) @(negedge clk);
    reset = 0;
    chk("boot_valid_low", {31'b0, req_valid}, 32'd0);

    // boot and sequential fetch
    req_ready = 1;
    tick();
    chk("first_valid", {31'b0, req_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("seq_addr", req_addr, 32'(i * 4));
      tick();
    end
    // now at 0x14; redirect back to 0x10 for the backpressure case
    redirect_valid = 1; redirect_target = 32'h10;
    tick();
    idle();
    req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr", req_addr, 32'h10);
    end
    req_ready = 1;
    tick();
    chk("resume_addr", req_addr, 32'h14);

    // priority: trap beats redirect
    trap_valid = 1; trap_pc = 32'h44; redirect_valid = 1; redirect_target = 32'h200;
    tick();
    idle();
    chk("trap_pc", req_addr, 32'h100);
    chk("trap_epc", epc, 32'h44);
    chk("trap_no_mis", {31'b0, misalign_exc}, 32'd0);
    redirect_valid = 1; redirect_target = 32'h202;
    tick();
    idle();
    chk("mis_pc", req_addr, 32'h100);
    chk("mis_epc", epc, 32'h202);
    chk("mis_pulse", {31'b0, misalign_exc}, 32'd1);
    tick();
    chk("mis_clear", {31'b0, misalign_exc}, 32'd0);
    chk("mis_next", req_addr, 32'h104);
    redirect_valid = 1; redirect_target = 32'h300;
    tick();
    idle();
    chk("redir_pc", req_addr, 32'h300);

    // RAS round trip with overflow
    for (int i = 1; i <= 5; i++) begin
      push(32'(i * 16));
      chk("push_count", {29'b0, ras_count}, (i > 4) ? 32'd4 : 32'(i));
    end
    for (int i = 0; i < 4; i++) begin
      pop();
      chk("pop_addr", req_addr, pops[i]);
    end
    pop();
    chk("miss_pulse", {31'b0, ret_miss}, 32'd1);
    chk("miss_seq", req_addr, 32'h24);
    tick();
    chk("miss_clear", {31'b0, ret_miss}, 32'd0);

    // simultaneous push/pop
    push(32'h20);
    push(32'h30);
    call_push = 1; push_addr = 32'h99; ret_pop = 1;
    tick();
    idle();
    chk("pp_addr", req_addr, 32'h30);
    chk("pp_count", {29'b0, ras_count}, 32'd2);
    pop();
    chk("pp_pop", req_addr, 32'h99);
    pop();
    chk("pp_pop2", req_addr, 32'h20);

    // async reset mid-run
    push(32'h1000);
    push(32'h2000);
    call_push = 1; push_addr = 32'h3000; redirect_valid = 1; redirect_target = 32'h80;
    tick();
    idle();
    chk("pre_rst_addr", req_addr, 32'h80);
    chk("pre_rst_count", {29'b0, ras_count}, 32'd3);
    #2 reset = 1;
    #1;
    chk("rst_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_addr", req_addr, RV);
    chk("rst_count", {29'b0, ras_count}, 32'd0);
    @(negedge clk);
    reset = 0;
    tick();
    chk("reboot_valid", {31'b0, req_valid}, 32'd1);
    chk("reboot_addr", req_addr, RV);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
